apb_sram_ctrl: RTL and testbench

//  APB3/APB4 completer that converts APB transfers into single-port SRAM cycles (cs/we/addr/din, 1-cycle read dout).

---
 rtl/apb_sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_apb_sram_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_sram_ctrl.sv
// apb_sram_ctrl: APB3/APB4 completer driving one single-port SRAM.
// Writes complete with zero wait states, reads with one, and out-of-range
// addresses return an error without touching the SRAM.
// Optional feature macro APB_SRAM_PSTRB_EN enables byte-strobe writes,
// implemented as read-modify-write. When the macro is undefined, pstrb is
// ignored and every write is a full-word write.
module apb_sram_ctrl #(
  parameter int mem_depth = 1024,
  parameter int mem_width = 32,
  parameter int mem_bitw  = 10,
  parameter int paddr_w   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [paddr_w-1:0]     paddr,
  input  logic [mem_width-1:0]   pwdata,
  input  logic [mem_width/8-1:0] pstrb,
  output logic [mem_width-1:0]   prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [mem_bitw-1:0]    sram_addr,
  output logic [mem_width-1:0]   sram_din,
  input  logic [mem_width-1:0]   sram_dout
);

  localparam int STRB_W = mem_width / 8;
  localparam logic [paddr_w:0] BYTE_LIMIT = (paddr_w+1)'(mem_depth * 4);

`ifdef APB_SRAM_PSTRB_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_A, S_RD_D, S_ERR, S_RMW_RD, S_RMW_MG, S_RMW_WR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_A, S_RD_D, S_ERR
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [mem_bitw-1:0]   addr_q, addr_d;
  logic [mem_width-1:0]  din_q, din_d;
  logic                  setup;
  logic                  addr_oob;
  logic                  strb_full;

`ifdef APB_SRAM_PSTRB_EN
  logic [STRB_W-1:0]     strb_q, strb_d;

  // Byte merge for read-modify-write: strobed bytes from the bus, rest from SRAM.
  function automatic logic [mem_width-1:0] merge_bytes(
    input logic [mem_width-1:0] wdata,
    input logic [mem_width-1:0] rdata,
    input logic [STRB_W-1:0]    strb
  );
    logic [mem_width-1:0] res;
    res = rdata;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction
`endif

  assign setup     = psel && !penable;
  assign addr_oob  = ({1'b0, paddr} >= BYTE_LIMIT);
  assign strb_full = &pstrb;

  // State, captured address/data (and strobes) registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef APB_SRAM_PSTRB_EN
      strb_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef APB_SRAM_PSTRB_EN
      strb_q  <= strb_d;
`endif
    end
  end

  // Next-state logic; address and write data are captured in the setup phase.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef APB_SRAM_PSTRB_EN
    strb_d  = strb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d = paddr[mem_bitw+1:2];
          din_d  = pwdata;
`ifdef APB_SRAM_PSTRB_EN
          strb_d = pstrb;
          if (addr_oob)       state_d = S_ERR;
          else if (!pwrite)   state_d = S_RD_A;
          else if (strb_full) state_d = S_WR;
          else                state_d = S_RMW_RD;
`else
          // Strobes are ignored here: partial writes become full-word writes.
          if (addr_oob)     state_d = S_ERR;
          else if (!pwrite) state_d = S_RD_A;
          else              state_d = strb_full ? S_WR : S_WR;
`endif
        end
      end
      S_WR:   state_d = S_IDLE;
      S_RD_A: state_d = S_RD_D;
      S_RD_D: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
`ifdef APB_SRAM_PSTRB_EN
      S_RMW_RD: state_d = S_RMW_MG;
      S_RMW_MG: begin
        din_d   = merge_bytes(din_q, sram_dout, strb_q);
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode: bus response and SRAM strobes depend on state only.
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    sram_cs = 1'b0;
    sram_we = 1'b0;
    case (state_q)
      S_WR: begin
        sram_cs = 1'b1;
        sram_we = 1'b1;
        pready  = 1'b1;
      end
      S_RD_A: sram_cs = 1'b1;
      S_RD_D: begin
        pready = 1'b1;
        prdata = sram_dout;
      end
      S_ERR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
`ifdef APB_SRAM_PSTRB_EN
      S_RMW_RD: sram_cs = 1'b1;
      S_RMW_WR: begin
        sram_cs = 1'b1;
        sram_we = 1'b1;
        pready  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign sram_addr = addr_q;
  assign sram_din  = din_q;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Testbench for apb_sram_ctrl: behavioural SRAM, reference memory and a
// scoreboard of expected APB responses.
module tb_apb_sram_ctrl;

  localparam int DEPTH = 1024;
  localparam int W     = 32;
  localparam int BITW  = 10;
  localparam int AW    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [W-1:0]    pwdata;
  logic [W/8-1:0]  pstrb;
  logic [W-1:0]    prdata;
  logic            pready, pslverr;
  logic            sram_cs, sram_we;
  logic [BITW-1:0] sram_addr;
  logic [W-1:0]    sram_din;
  logic [W-1:0]    sram_dout;

  always #5 clk = ~clk;

  apb_sram_ctrl #(
    .mem_depth(DEPTH), .mem_width(W), .mem_bitw(BITW), .paddr_w(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [W-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      else         sram_dout <= sram_mem[sram_addr];
    end
  end

  logic [W-1:0] ref_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          waits;
    int          cs_cnt;
  } exp_t;

  exp_t sb[$];

  // One APB transfer; called right after a rising edge, returns right after
  // the rising edge that completes the transfer (so calls chain back-to-back).
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input string tag);
    exp_t        e, got_e;
    logic [9:0]  word;
    logic [31:0] cur, merged;
    int          waits, cs_cnt;
    bit          done, first;

    word     = addr[11:2];
    e.err    = (addr >= 16'h1000);
    e.data   = '0;
    e.waits  = 0;
    e.cs_cnt = 0;
    if (!e.err) begin
      if (wr) begin
        cur      = ref_mem[word];
        merged   = wdata;
        e.cs_cnt = 1;
`ifdef APB_SRAM_PSTRB_EN
        if (strb != 4'hF) begin
          for (int i = 0; i < 4; i++)
            merged[i*8 +: 8] = strb[i] ? wdata[i*8 +: 8] : cur[i*8 +: 8];
          e.waits  = 2;
          e.cs_cnt = 2;
        end
`endif
        ref_mem[word] = merged;
      end else begin
        e.data   = ref_mem[word];
        e.waits  = 1;
        e.cs_cnt = 1;
      end
    end
    sb.push_back(e);

    #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge clk);
    #1 penable = 1'b1;

    waits  = 0;
    cs_cnt = 0;
    done   = 1'b0;
    first  = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (sram_cs) cs_cnt++;
      if (first && !e.err) begin
        check_val({tag, ".addr"}, 32'(sram_addr), 32'(word));
        check_val({tag, ".cs1"}, 32'(sram_cs), 32'd1);
        check_val({tag, ".we1"}, 32'(sram_we), 32'((wr && e.waits == 0) ? 1 : 0));
        if (wr && e.waits == 0) begin
          check_val({tag, ".din"}, sram_din, wdata);
          check_val({tag, ".prd0"}, prdata, 32'd0);
        end
      end
      first = 1'b0;
      if (pready) begin
        done  = 1'b1;
        got_e = sb.pop_front();
        check_val({tag, ".err"}, 32'(pslverr), 32'(got_e.err));
        check_val({tag, ".prdata"}, prdata, got_e.data);
        check_val({tag, ".waits"}, waits, got_e.waits);
        check_val({tag, ".cs_cnt"}, cs_cnt, got_e.cs_cnt);
      end else begin
        waits++;
      end
    end
    if (!done) begin
      check_val({tag, ".timeout"}, 32'd1, 32'd0);
      void'(sb.pop_front());
    end
    @(posedge clk);
  endtask

  logic [AW-1:0] ra;
  logic [31:0]   rd;
  logic [3:0]    rs;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_dout = '0;
    rst     = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst.pready", 32'(pready), 32'd0);
    check_val("rst.pslverr", 32'(pslverr), 32'd0);
    check_val("rst.cs", 32'(sram_cs), 32'd0);
    check_val("rst.we", 32'(sram_we), 32'd0);
    check_val("rst.prdata", prdata, 32'd0);
    check_val("rst.addr", 32'(sram_addr), 32'd0);
    check_val("rst.din", sram_din, 32'd0);
    @(posedge clk);

    apb_xfer(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, "wr4");
    apb_xfer(1'b0, 16'h0004, 32'h0, 4'hF, "rd4");
    apb_xfer(1'b0, 16'h1000, 32'h0, 4'hF, "rd_oob");
    apb_xfer(1'b1, 16'h1000, 32'hCAFEF00D, 4'hF, "wr_oob");
    apb_xfer(1'b0, 16'h0000, 32'h0, 4'hF, "rd0");
    apb_xfer(1'b1, 16'h0FFC, 32'h12345678, 4'hF, "wr_top");
    apb_xfer(1'b0, 16'h0FFC, 32'h0, 4'hF, "rd_top");
    apb_xfer(1'b0, 16'hFFFC, 32'h0, 4'hF, "rd_far");

    // Access phase with no preceding setup must be ignored.
    #1;
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 16'h0004;
    pwdata  = 32'h0BADBAD0;
    @(posedge clk);
    @(negedge clk);
    check_val("noset.pready", 32'(pready), 32'd0);
    check_val("noset.cs", 32'(sram_cs), 32'd0);
    @(posedge clk);
    #1 psel = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    apb_xfer(1'b0, 16'h0004, 32'h0, 4'hF, "rd4_again");

    // Byte strobes: read-modify-write when enabled, full word otherwise.
    apb_xfer(1'b1, 16'h0008, 32'hAABBCCDD, 4'hF, "wr8");
    apb_xfer(1'b1, 16'h0008, 32'h11223344, 4'b0101, "wr8_strb");
    apb_xfer(1'b0, 16'h0008, 32'h0, 4'hF, "rd8");
    apb_xfer(1'b1, 16'h0008, 32'h55667788, 4'b0000, "wr8_nostrb");
    apb_xfer(1'b0, 16'h0008, 32'h0, 4'hF, "rd8_b");

    // Mixed traffic to scattered addresses.
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom_range(0, 16'h1100)) & 16'hFFFC;
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      apb_xfer(1'($urandom_range(0, 1)), ra, rd, rs, "mix");
    end
    for (int n = 0; n < 8; n++) begin
      ra = 16'(n * 4);
      apb_xfer(1'b0, ra, 32'h0, 4'hF, "sweep");
    end

    #1 psel = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    check_val("sb.empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
